// File: rtl/collision_scheduler.sv
// collision_scheduler: shares one combinational block-collision checker among
// N_SPRITES sprites each frame. Positions are snapshotted on frame_start, fed
// to the checker one slot at a time with a settle window, and the captured
// left/right flags are published together with a one-cycle results_valid.
module collision_scheduler #(
  parameter int N_SPRITES     = 4,
  parameter int W             = 18,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_start,
  input  logic [N_SPRITES-1:0]   sprite_active,
  input  logic [N_SPRITES*W-1:0] sprite_x,
  input  logic [N_SPRITES*W-1:0] sprite_y,
  input  logic [W-1:0]           background_offset,
  output logic [W-1:0]           chk_x,
  output logic [W-1:0]           chk_y,
  output logic [W-1:0]           chk_offset,
  input  logic                   chk_left,
  input  logic                   chk_right,
  output logic [N_SPRITES-1:0]   coll_left,
  output logic [N_SPRITES-1:0]   coll_right,
  output logic                   results_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int IW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_SPRITES - 1);
  localparam logic [3:0]    SETTLE_END = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SNAP, ISSUE, SETTLE, CAPTURE, PUBLISH
  } state_t;

  state_t               state_reg;
  logic [IW-1:0]        idx_reg;
  logic [3:0]           settle_cnt_reg;
  logic [N_SPRITES-1:0] work_left_reg,  work_left_next;
  logic [N_SPRITES-1:0] work_right_reg, work_right_next;

  logic [W-1:0]         shadow_x_reg [N_SPRITES];
  logic [W-1:0]         shadow_y_reg [N_SPRITES];
  logic [N_SPRITES-1:0] shadow_active_reg;
  logic [W-1:0]         shadow_offset_reg;

  // Shadow copies are loaded only in SNAP so the scan ignores later input changes
  generate
    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_shadow
      always_ff @(posedge Clk) begin
        if (state_reg == SNAP) begin
          shadow_x_reg[gi] <= sprite_x[gi*W +: W];
          shadow_y_reg[gi] <= sprite_y[gi*W +: W];
        end
      end
    end
  endgenerate

  // Active mask and scroll offset are snapshotted alongside the positions
  always_ff @(posedge Clk) begin
    if (state_reg == SNAP) begin
      shadow_active_reg <= sprite_active;
      shadow_offset_reg <= background_offset;
    end
  end

  // Working flag update for the current slot: cleared when skipped, loaded on capture
  always_comb begin
    work_left_next  = work_left_reg;
    work_right_next = work_right_reg;
    if (state_reg == ISSUE && !shadow_active_reg[idx_reg]) begin
      work_left_next[idx_reg]  = 1'b0;
      work_right_next[idx_reg] = 1'b0;
    end else if (state_reg == CAPTURE) begin
      work_left_next[idx_reg]  = chk_left;
      work_right_next[idx_reg] = chk_right;
    end
  end

  // Scan FSM with registered checker drive and published outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      settle_cnt_reg <= '0;
      work_left_reg  <= '0;
      work_right_reg <= '0;
      chk_x          <= '0;
      chk_y          <= '0;
      chk_offset     <= '0;
      coll_left      <= '0;
      coll_right     <= '0;
      results_valid  <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      // A new frame while a scan is in flight is dropped and flagged
      if (frame_start && busy) begin
        overrun <= 1'b1;
      end
      work_left_reg  <= work_left_next;
      work_right_reg <= work_right_next;

      case (state_reg)
        IDLE: begin
          if (frame_start) begin
            state_reg <= SNAP;
            busy      <= 1'b1;
          end
        end
        SNAP: begin
          idx_reg   <= '0;
          state_reg <= ISSUE;
        end
        ISSUE: begin
          if (shadow_active_reg[idx_reg]) begin
            chk_x          <= shadow_x_reg[idx_reg];
            chk_y          <= shadow_y_reg[idx_reg];
            chk_offset     <= shadow_offset_reg;
            settle_cnt_reg <= '0;
            state_reg      <= SETTLE;
          end else if (idx_reg == LAST_IDX) begin
            // Published flags load on entry to PUBLISH so they appear with results_valid
            coll_left     <= work_left_next;
            coll_right    <= work_right_next;
            results_valid <= 1'b1;
            state_reg     <= PUBLISH;
          end else begin
            idx_reg   <= idx_reg + IW'(1);
            state_reg <= ISSUE;
          end
        end
        SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg + 4'd1;
          if (settle_cnt_reg == SETTLE_END) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (idx_reg == LAST_IDX) begin
            coll_left     <= work_left_next;
            coll_right    <= work_right_next;
            results_valid <= 1'b1;
            state_reg     <= PUBLISH;
          end else begin
            idx_reg   <= idx_reg + IW'(1);
            state_reg <= ISSUE;
          end
        end
        PUBLISH: begin
          results_valid <= 1'b0;
          busy          <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a behavioural checker model that
// flags left/right when chk_x matches a programmable target coordinate.
module tb_collision_scheduler;
  localparam int N = 4;
  localparam int W = 18;
  localparam int S = 2;

  logic           clk;
  logic           rst_n;
  logic           frame_start;
  logic [N-1:0]   sprite_active;
  logic [N*W-1:0] sprite_x;
  logic [N*W-1:0] sprite_y;
  logic [W-1:0]   background_offset;
  logic [W-1:0]   chk_x, chk_y, chk_offset;
  logic           chk_left, chk_right;
  logic [N-1:0]   coll_left, coll_right;
  logic           results_valid, busy, overrun;

  logic [W-1:0]   left_target, right_target;

  int checks = 0;
  int errors = 0;

  collision_scheduler #(.N_SPRITES(N), .W(W), .SETTLE_CYCLES(S)) dut (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start),
    .sprite_active(sprite_active), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .background_offset(background_offset),
    .chk_x(chk_x), .chk_y(chk_y), .chk_offset(chk_offset),
    .chk_left(chk_left), .chk_right(chk_right),
    .coll_left(coll_left), .coll_right(coll_right),
    .results_valid(results_valid), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker model: combinational from chk_x
  always_comb begin
    chk_left  = (chk_x == left_target);
    chk_right = (chk_x == right_target);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int i, input logic [W-1:0] v);
    sprite_x[i*W +: W] = v;
  endtask

  // Runs one scan from the sampling point (posedge+1); n counts cycles with
  // n=1 being the SNAP cycle. Monitors coll_* hold and forbidden chk_x values.
  task automatic scan(input string tag, input int exp_lat, input int fs_at,
                      input int chg_at, input logic [W-1:0] chg_val,
                      input logic [W-1:0] bad_lo, input logic [W-1:0] bad_hi);
    int n;
    logic held, seen_bad;
    logic [N-1:0] prev_l, prev_r;
    prev_l = coll_left;
    prev_r = coll_right;
    held = 1'b1;
    seen_bad = 1'b0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 1;
    while (!results_valid && n < 100) begin
      if (coll_left !== prev_l || coll_right !== prev_r) held = 1'b0;
      if (chk_x >= bad_lo && chk_x <= bad_hi) seen_bad = 1'b1;
      frame_start = (n == fs_at);
      if (n == chg_at) set_x(0, chg_val);
      @(posedge clk); #1;
      n++;
    end
    frame_start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_coll_held"}, {31'd0, held}, 32'd1);
    check({tag, "_no_bad_chk"}, {31'd0, seen_bad}, 32'd0);
    check({tag, "_busy_in_publish"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_valid_one_cycle"}, {31'd0, results_valid}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    frame_start = 1'b0;
    sprite_active = '0;
    sprite_x = '0;
    sprite_y = '0;
    background_offset = '0;
    left_target = 18'h3FFFF;
    right_target = 18'h3FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_chk_x", 32'(chk_x), 32'd0);
    check("rst_coll_left", 32'(coll_left), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A: all active, slot 2 collides on the left
    sprite_active = 4'b1111;
    for (int i = 0; i < N; i++) begin
      set_x(i, 18'(10 + i));
      sprite_y[i*W +: W] = 18'(20 + i);
    end
    background_offset = 18'd5;
    left_target = 18'd12;
    right_target = 18'h3FFFF;
    scan("A", 18, 0, 0, '0, 18'd1, 18'd0);
    check("A_coll_left", 32'(coll_left), 32'b0100);
    check("A_coll_right", 32'(coll_right), 32'd0);
    check("A_chk_x_hold", 32'(chk_x), 32'd13);
    check("A_chk_y_hold", 32'(chk_y), 32'd23);
    check("A_chk_offset", 32'(chk_offset), 32'd5);

    // B: only slot 0 active, right hit; slot 0 X changes after the snapshot
    sprite_active = 4'b0001;
    set_x(0, 18'd30);
    for (int i = 1; i < N; i++) set_x(i, 18'(40 + i));
    right_target = 18'd30;
    scan("B", 9, 0, 2, 18'd99, 18'd41, 18'd99);
    check("B_coll_right", 32'(coll_right), 32'b0001);
    check("B_coll_left", 32'(coll_left), 32'd0);
    check("B_chk_x_snapshot", 32'(chk_x), 32'd30);
    check("B_overrun_clear", {31'd0, overrun}, 32'd0);

    // C: second frame_start at cycle 5 of the scan -> overrun, scan unaffected
    sprite_active = 4'b1111;
    for (int i = 0; i < N; i++) set_x(i, 18'(10 + i));
    right_target = 18'h3FFFF;
    scan("C", 18, 5, 0, '0, 18'd1, 18'd0);
    check("C_overrun", {31'd0, overrun}, 32'd1);
    check("C_coll_left", 32'(coll_left), 32'b0100);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("C_no_second_scan", {31'd0, seen}, 32'd0);
    check("C_overrun_sticky", {31'd0, overrun}, 32'd1);

    // D: back-to-back frames with different results
    left_target = 18'd11;
    scan("D1", 18, 0, 0, '0, 18'd1, 18'd0);
    check("D1_coll_left", 32'(coll_left), 32'b0010);
    left_target = 18'd10;
    right_target = 18'd13;
    scan("D2", 18, 0, 0, '0, 18'd1, 18'd0);
    check("D2_coll_left", 32'(coll_left), 32'b0001);
    check("D2_coll_right", 32'(coll_right), 32'b1000);

    // E: reset asserted mid-SETTLE clears everything at once
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("E_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("E_coll_left", 32'(coll_left), 32'd0);
    check("E_coll_right", 32'(coll_right), 32'd0);
    check("E_chk_x", 32'(chk_x), 32'd0);
    check("E_busy", {31'd0, busy}, 32'd0);
    check("E_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy || results_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("E_idle_after", {31'd0, seen}, 32'd0);
    check("E_coll_after", 32'(coll_left), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
